// File: rtl/lorenz_euler_stream.sv
// lorenz_euler_stream: streaming fixed-point Euler integrator for the Lorenz system with backpressure and overflow flag
module lorenz_euler_stream #(
    parameter int W = 28,
    parameter int FRAC = 17,
    parameter int N_STEPS = 1024,
    parameter int DT_SHIFT = 7,
    parameter logic signed [W-1:0] SIGMA = W'(10 << 17),
    parameter logic signed [W-1:0] RHO = W'(28 << 17),
    parameter logic signed [W-1:0] BETA = W'(349525),
    localparam int CW = $clog2(N_STEPS + 1)
) (
    input  logic          CLK_i,
    input  logic          RST_i,
    input  logic          START_i,
    input  logic [W-1:0]  X0_i,
    input  logic [W-1:0]  Y0_i,
    input  logic [W-1:0]  Z0_i,
    input  logic          READY_i,
    output logic          VALID_o,
    output logic [W-1:0]  X_o,
    output logic [W-1:0]  Y_o,
    output logic [W-1:0]  Z_o,
    output logic [CW-1:0] STEP_o,
    output logic          BUSY_o,
    output logic          FINISHED_o,
    output logic          OVF_o
);
    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, UPD, EMIT, DONE} state_t;
    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    state_t state_q;
    logic signed [W-1:0] x_q, y_q, z_q, p0_q, p1_q, p2_q, p3_q;
    logic [CW-1:0] step_q;
    logic valid_q, busy_q, fin_q, ovf_q;
    function automatic logic [W:0] ext(input logic [W-1:0] v);
        return {v[W-1], v};
    endfunction
    function automatic logic signed [W-1:0] sat1(input logic [W:0] v);
        return (v[W] ^ v[W-1]) ? (v[W] ? MINV : MAXV) : v[W-1:0];
    endfunction
    logic [W:0] yx_w, rz_w, dy_w, dz_w, x_w, y_w, z_w;
    logic signed [W-1:0] yx, rz, dy, dz, ma, mb, p, x_d, y_d, z_d;
    logic signed [2*W-1:0] prod, sh;
    logic [W:0] sh_hi;
    logic p_of, mul_st, ovf_ev;
    assign yx_w = ext(y_q) - ext(x_q);
    assign rz_w = ext(RHO) - ext(z_q);
    assign yx = sat1(yx_w);
    assign rz = sat1(rz_w);
    assign ma = (state_q == M0) ? SIGMA : (state_q == M3) ? BETA : x_q;
    assign mb = (state_q == M0) ? yx : (state_q == M1) ? rz : (state_q == M2) ? y_q : z_q;
    // full-width product, rescaled, then clamped if the discarded high bits are not pure sign
    assign prod = (2*W)'(ma) * (2*W)'(mb);
    assign sh = prod >>> FRAC;
    assign sh_hi = sh[2*W-1:W-1];
    assign p_of = !((&sh_hi) | ~(|sh_hi));
    assign p = p_of ? (sh[2*W-1] ? MINV : MAXV) : sh[W-1:0];
    assign dy_w = ext(p1_q) - ext(y_q);
    assign dz_w = ext(p2_q) - ext(p3_q);
    assign dy = sat1(dy_w);
    assign dz = sat1(dz_w);
    assign x_w = ext(x_q) + ext(p0_q >>> DT_SHIFT);
    assign y_w = ext(y_q) + ext(dy >>> DT_SHIFT);
    assign z_w = ext(z_q) + ext(dz >>> DT_SHIFT);
    assign x_d = sat1(x_w);
    assign y_d = sat1(y_w);
    assign z_d = sat1(z_w);
    assign mul_st = (state_q == M0) | (state_q == M1) | (state_q == M2) | (state_q == M3);
    assign ovf_ev = (mul_st & p_of) | ((state_q == M0) & (yx_w[W] ^ yx_w[W-1]))
                  | ((state_q == M1) & (rz_w[W] ^ rz_w[W-1]))
                  | ((state_q == UPD) & ((dy_w[W] ^ dy_w[W-1]) | (dz_w[W] ^ dz_w[W-1])
                  | (x_w[W] ^ x_w[W-1]) | (y_w[W] ^ y_w[W-1]) | (z_w[W] ^ z_w[W-1])));
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            p0_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
            step_q <= '0;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
            fin_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (ovf_ev) ovf_q <= 1'b1;
            case (state_q)
                IDLE: if (START_i) begin
                    x_q <= X0_i;
                    y_q <= Y0_i;
                    z_q <= Z0_i;
                    step_q <= '0;
                    ovf_q <= 1'b0;
                    busy_q <= 1'b1;
                    state_q <= M0;
                end
                M0: begin p0_q <= p; state_q <= M1; end
                M1: begin p1_q <= p; state_q <= M2; end
                M2: begin p2_q <= p; state_q <= M3; end
                M3: begin p3_q <= p; state_q <= UPD; end
                UPD: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    step_q <= step_q + CW'(1);
                    valid_q <= 1'b1;
                    state_q <= EMIT;
                end
                EMIT: if (READY_i) begin
                    valid_q <= 1'b0;
                    busy_q <= (step_q != CW'(N_STEPS));
                    fin_q <= (step_q == CW'(N_STEPS));
                    state_q <= (step_q == CW'(N_STEPS)) ? DONE : M0;
                end
                DONE: begin fin_q <= 1'b0; state_q <= IDLE; end
            endcase
        end
    end
    assign VALID_o = valid_q;
    assign X_o = x_q;
    assign Y_o = y_q;
    assign Z_o = z_q;
    assign STEP_o = step_q;
    assign BUSY_o = busy_q;
    assign FINISHED_o = fin_q;
    assign OVF_o = ovf_q;
endmodule

// File: tb/tb_lorenz_euler_stream.sv
// tb_lorenz_euler_stream: randomized handshake bench against a plain-arithmetic Lorenz Euler reference
module tb_lorenz_euler_stream;
    localparam int W = 28;
    localparam int FRAC = 17;
    localparam int N = 12;
    localparam int DT = 7;
    localparam int CW = $clog2(N + 1);
    localparam longint SIGMA = 10 << 17;
    localparam longint RHO = 28 << 17;
    localparam longint BETA = 349525;
    localparam longint ONE = 1 << FRAC;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W - 1));
    logic CLK_i = 1'b0, RST_i = 1'b1, START_i = 1'b0, READY_i = 1'b0;
    logic [W-1:0] X0_i = '0, Y0_i = '0, Z0_i = '0;
    logic VALID_o, BUSY_o, FINISHED_o, OVF_o;
    logic [W-1:0] X_o, Y_o, Z_o;
    logic [CW-1:0] STEP_o;
    int n_chk = 0, n_pass = 0, n_stall = 0;
    longint mx, my, mz, f_x, f_y, f_z;
    int mstep;
    bit m_ovf, f_ovf;

    lorenz_euler_stream #(.W(W), .FRAC(FRAC), .N_STEPS(N), .DT_SHIFT(DT)) dut (
        .CLK_i(CLK_i), .RST_i(RST_i), .START_i(START_i), .X0_i(X0_i), .Y0_i(Y0_i), .Z0_i(Z0_i),
        .READY_i(READY_i), .VALID_o(VALID_o), .X_o(X_o), .Y_o(Y_o), .Z_o(Z_o), .STEP_o(STEP_o),
        .BUSY_o(BUSY_o), .FINISHED_o(FINISHED_o), .OVF_o(OVF_o)
    );

    always #5 CLK_i = ~CLK_i;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint sat(input longint v);
        if (v > MAXV) begin m_ovf = 1'b1; return MAXV; end
        if (v < MINV) begin m_ovf = 1'b1; return MINV; end
        return v;
    endfunction

    function automatic longint mul(input longint a, input longint b);
        return sat((a * b) >>> FRAC);
    endfunction

    task automatic model_step();
        longint p0, p1, p2, p3, dy, dz;
        p0 = mul(SIGMA, sat(my - mx));
        p1 = mul(mx, sat(RHO - mz));
        p2 = mul(mx, my);
        p3 = mul(BETA, mz);
        dy = sat(p1 - my);
        dz = sat(p2 - p3);
        mx = sat(mx + (p0 >>> DT));
        my = sat(my + (dy >>> DT));
        mz = sat(mz + (dz >>> DT));
        mstep++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, VALID_o, 0);
        check({tag, "_x"}, X_o, 0);
        check({tag, "_y"}, Y_o, 0);
        check({tag, "_z"}, Z_o, 0);
        check({tag, "_step"}, STEP_o, 0);
        check({tag, "_busy"}, BUSY_o, 0);
        check({tag, "_fin"}, FINISHED_o, 0);
        check({tag, "_ovf"}, OVF_o, 0);
    endtask

    task automatic run(input longint x0, input longint y0, input longint z0,
                       input int ready_pct, input int hold_step, input bit poke);
        int cyc, last_v, hold_left;
        bit pend, done, xfer;
        @(negedge CLK_i);
        START_i = 1'b1;
        X0_i = W'(x0);
        Y0_i = W'(y0);
        Z0_i = W'(z0);
        @(negedge CLK_i);
        START_i = 1'b0;
        mx = x0; my = y0; mz = z0; mstep = 0; m_ovf = 1'b0;
        check("busy_start", BUSY_o, 1);
        check("ovf_clear", OVF_o, 0);
        check("valid_start", VALID_o, 0);
        cyc = 1; last_v = 0; hold_left = 0; pend = 0; done = 0; n_stall = 0;
        while (!done && cyc < 3000) begin
            if (pend) begin
                check("valid_held", VALID_o, 1);
                if (mstep == hold_step) n_stall++;
            end
            if (VALID_o) begin
                if (!pend) begin
                    model_step();
                    if (mstep == 1) begin f_x = mx; f_y = my; f_z = mz; f_ovf = OVF_o; end
                    if (ready_pct == 100 && hold_step == 0) check("spacing", cyc - last_v, 6);
                    last_v = cyc;
                    pend = 1;
                    hold_left = (mstep == hold_step) ? 10 : 0;
                end
                check("x", $signed(X_o), mx);
                check("y", $signed(Y_o), my);
                check("z", $signed(Z_o), mz);
                check("step", STEP_o, mstep);
                check("ovf", OVF_o, m_ovf);
                READY_i = (hold_left > 0) ? 1'b0 : ($urandom_range(99) < ready_pct);
                if (hold_left > 0) hold_left--;
            end else begin
                READY_i = ($urandom_range(99) < ready_pct);
            end
            if (poke) begin
                START_i = 1'($urandom_range(1));
                X0_i = W'($urandom);
                Y0_i = W'($urandom);
                Z0_i = W'($urandom);
            end
            xfer = VALID_o && READY_i;
            @(negedge CLK_i);
            cyc++;
            if (xfer) begin
                pend = 0;
                if (mstep == N) begin
                    check("fin_rise", FINISHED_o, 1);
                    check("busy_drop", BUSY_o, 0);
                    done = 1;
                end else begin
                    check("fin_early", FINISHED_o, 0);
                    check("valid_after_xfer", VALID_o, 0);
                end
            end
        end
        check("run_done", done, 1);
        START_i = poke;
        @(negedge CLK_i);
        START_i = 1'b0;
        X0_i = '0; Y0_i = '0; Z0_i = '0;
        check("fin_pulse", FINISHED_o, 0);
        repeat (3) @(negedge CLK_i);
        check("idle_busy", BUSY_o, 0);
        check("idle_valid", VALID_o, 0);
        check("retain_x", $signed(X_o), mx);
        check("retain_z", $signed(Z_o), mz);
        check("retain_step", STEP_o, N);
        check("samples", mstep, N);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge CLK_i);
        check_zero("reset");
        RST_i = 1'b0;
        run(ONE, ONE, ONE, 100, 0, 0);
        check("t1_x", f_x, 'h20000);
        check("t1_y", f_y, 'h26800);
        check("t1_z", f_z, 129365);
        check("t1_ovf", f_ovf, 0);
        run(0, 0, 0, 100, 0, 0);
        check("zero_x", mx, 0);
        run('h7E00000, 'h7E00000, 0, 70, 0, 0);
        check("sat_ovf_step1", f_ovf, 1);
        check("sat_ovf_end", OVF_o, 1);
        run(ONE, ONE, ONE, 60, 2, 0);
        check("hold_cycles", n_stall >= 10, 1);
        @(negedge CLK_i);
        START_i = 1'b1;
        X0_i = W'(ONE); Y0_i = W'(ONE); Z0_i = W'(ONE);
        @(negedge CLK_i);
        START_i = 1'b0;
        READY_i = 1'b1;
        repeat (14) @(negedge CLK_i);
        check("mid_step", STEP_o, 2);
        check("mid_busy", BUSY_o, 1);
        RST_i = 1'b1;
        @(negedge CLK_i);
        check_zero("abort");
        RST_i = 1'b0;
        repeat (8) begin
            @(negedge CLK_i);
            check("abort_fin", FINISHED_o, 0);
        end
        run(ONE, ONE, ONE, 100, 0, 0);
        check("t5_x", f_x, 'h20000);
        check("t5_y", f_y, 'h26800);
        check("t5_z", f_z, 129365);
        for (int i = 0; i < 2; i++)
            run(longint'($urandom_range(0, 20 << 17)) - (10 << 17),
                longint'($urandom_range(0, 20 << 17)) - (10 << 17),
                longint'($urandom_range(0, 40 << 17)), 50, 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
